// File: rtl/copro_pkg.sv
// Shared opcodes, transmit FSM state type and opcode classification helpers
// for the coprocessor execution/response path.
package copro_pkg;

    localparam logic [7:0] OP_IDLE = 8'd0;
    localparam logic [7:0] OP_WR_A = 8'd97;
    localparam logic [7:0] OP_WR_B = 8'd98;
    localparam logic [7:0] OP_RD_A = 8'd99;
    localparam logic [7:0] OP_RD_B = 8'd100;
    localparam logic [7:0] OP_SUM  = 8'd101;
    localparam logic [7:0] OP_AVG  = 8'd102;
    localparam logic [7:0] OP_MAN  = 8'd103;
    localparam logic [7:0] OP_EUC  = 8'd104;

    localparam int ACC_W_DEFAULT = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_MEMWAIT,
        ST_LOAD,
        ST_SEND,
        ST_TXWAIT,
        ST_HOLD
    } tx_state_t;

    function automatic logic is_valid_op(input logic [7:0] o);
        return (o >= OP_RD_A) && (o <= OP_EUC);
    endfunction

    function automatic logic uses_a(input logic [7:0] o);
        return (o == OP_RD_A) || ((o >= OP_SUM) && (o <= OP_EUC));
    endfunction

    function automatic logic uses_b(input logic [7:0] o);
        return (o >= OP_RD_B) && (o <= OP_EUC);
    endfunction

    function automatic logic is_dist(input logic [7:0] o);
        return (o == OP_MAN) || (o == OP_EUC);
    endfunction

    // Per-element ops stream a response for every vector index.
    function automatic logic is_per_elem(input logic [7:0] o);
        return (o >= OP_RD_A) && (o <= OP_AVG);
    endfunction

endpackage

// File: rtl/vec_tx_sequencer_dist_acc.sv
// vec_dist_acc: Manhattan / squared-Euclidean distance accumulator.
// Difference, magnitude and square are combinational; only the sum is registered.
module vec_dist_acc
    import copro_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clear,
    input  logic             i_acc_en,
    input  logic             i_mode_euc,
    input  logic [7:0]       i_a,
    input  logic [7:0]       i_b,
    output logic [ACC_W-1:0] o_acc
);

    logic signed [16:0] w_diff;
    logic signed [33:0] w_sq;
    logic [7:0]         w_abs;
    logic [ACC_W-1:0]   w_term;
    logic [ACC_W-1:0]   r_acc;

    assign w_diff = $signed({9'b0, i_a}) - $signed({9'b0, i_b});
    assign w_sq   = w_diff * w_diff;
    assign w_abs  = (i_a >= i_b) ? (i_a - i_b) : (i_b - i_a);
    assign w_term = i_mode_euc ? ACC_W'(w_sq) : ACC_W'(w_abs);

    // Wraps modulo 2^ACC_W for very long vectors.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc <= '0;
        end else if (i_clear) begin
            r_acc <= '0;
        end else if (i_acc_en) begin
            r_acc <= r_acc + w_term;
        end
    end

    assign o_acc = r_acc;

endmodule

// File: rtl/vec_tx_sequencer.sv
// Executes a decoded vector op, streams result bytes to the UART and pulses op_finished.
// Define COPRO_TX_HEADER_EN to send the latched opcode as a header byte first.
module vec_tx_sequencer
    import copro_pkg::*;
#(
    parameter int VEC_LEN = 1024,
    parameter int ADDR_W  = $clog2(VEC_LEN),
    parameter int ACC_W   = ACC_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        op,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              rd_en_a,
    output logic              rd_en_b,
    input  logic [7:0]        dout_a,
    input  logic [7:0]        dout_b,
    output logic [7:0]        tx_data,
    output logic              tx_start,
    input  logic              tx_busy,
    output logic              op_finished
);

    tx_state_t         r_state;
    tx_state_t         w_next;
    logic [7:0]        r_op;
    logic [ADDR_W-1:0] r_idx;
    logic [31:0]       r_buf;
    logic [2:0]        r_cnt;
    logic              r_first;
    logic              r_dist_last;
`ifdef COPRO_TX_HEADER_EN
    logic              r_hdr_pending;
`endif

    logic              w_last;
    logic              w_acc_clr;
    logic              w_acc_en;
    logic              w_idx_inc;
    logic [8:0]        w_sum;
    logic [ACC_W-1:0]  w_acc;

    assign w_last   = (r_idx == ADDR_W'(VEC_LEN - 1));
    assign w_sum    = {1'b0, dout_a} + {1'b0, dout_b};
    assign mem_addr = r_idx;
    assign tx_data  = r_buf[31:24];

    vec_dist_acc #(.ACC_W(ACC_W)) u_acc (
        .clk        (clk),
        .rst        (rst),
        .i_clear    (w_acc_clr),
        .i_acc_en   (w_acc_en),
        .i_mode_euc (r_op == OP_EUC),
        .i_a        (dout_a),
        .i_b        (dout_b),
        .o_acc      (w_acc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        rd_en_a     = 1'b0;
        rd_en_b     = 1'b0;
        tx_start    = 1'b0;
        op_finished = 1'b0;
        w_acc_clr   = 1'b0;
        w_acc_en    = 1'b0;
        w_idx_inc   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (is_valid_op(op)) begin
                    w_acc_clr = 1'b1;
`ifdef COPRO_TX_HEADER_EN
                    w_next = ST_SEND;
`else
                    w_next = ST_READ;
`endif
                end
            end
            ST_READ: begin
                rd_en_a = uses_a(r_op);
                rd_en_b = uses_b(r_op);
                w_next  = ST_MEMWAIT;
            end
            ST_MEMWAIT: w_next = ST_LOAD;
            ST_LOAD: begin
                // The last distance element takes an extra LOAD cycle so the
                // registered sum includes it before being copied to the buffer.
                if (is_dist(r_op)) begin
                    if (!w_last) begin
                        w_acc_en = 1'b1;
                        w_next   = ST_READ;
                    end else if (!r_dist_last) begin
                        w_acc_en = 1'b1;
                    end else begin
                        w_next = ST_SEND;
                    end
                end else begin
                    w_next = ST_SEND;
                end
            end
            ST_SEND: begin
                if (!tx_busy) begin
                    tx_start = 1'b1;
                    w_next   = ST_TXWAIT;
                end
            end
            ST_TXWAIT: begin
                if (!r_first && !tx_busy) begin
                    if (r_cnt != 3'd0) begin
                        w_next = ST_SEND;
                    end
`ifdef COPRO_TX_HEADER_EN
                    else if (r_hdr_pending) begin
                        w_next = ST_READ;
                    end
`endif
                    else if (is_per_elem(r_op) && !w_last) begin
                        w_idx_inc = 1'b1;
                        w_next    = ST_READ;
                    end else begin
                        op_finished = 1'b1;
                        w_next      = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (!is_valid_op(op)) begin
                    w_next = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op          <= OP_IDLE;
            r_idx         <= '0;
            r_buf         <= '0;
            r_cnt         <= '0;
            r_first       <= 1'b0;
            r_dist_last   <= 1'b0;
`ifdef COPRO_TX_HEADER_EN
            r_hdr_pending <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (is_valid_op(op)) begin
                        r_op        <= op;
                        r_idx       <= '0;
                        r_dist_last <= 1'b0;
`ifdef COPRO_TX_HEADER_EN
                        r_buf         <= {op, 24'b0};
                        r_cnt         <= 3'd1;
                        r_hdr_pending <= 1'b1;
`endif
                    end
                end
                ST_LOAD: begin
                    if (is_dist(r_op)) begin
                        if (!w_last) begin
                            r_idx <= r_idx + 1'b1;
                        end else if (!r_dist_last) begin
                            r_dist_last <= 1'b1;
                        end else begin
                            r_buf <= 32'(w_acc);
                            r_cnt <= 3'd4;
                        end
                    end else begin
                        case (r_op)
                            OP_RD_A: begin
                                r_buf <= {dout_a, 24'b0};
                                r_cnt <= 3'd1;
                            end
                            OP_RD_B: begin
                                r_buf <= {dout_b, 24'b0};
                                r_cnt <= 3'd1;
                            end
                            OP_SUM: begin
                                r_buf <= {7'b0, w_sum, 16'b0};
                                r_cnt <= 3'd2;
                            end
                            default: begin
                                r_buf <= {w_sum[8:1], 24'b0};
                                r_cnt <= 3'd1;
                            end
                        endcase
                    end
                end
                ST_SEND: begin
                    if (tx_start) begin
                        r_buf   <= r_buf << 8;
                        r_cnt   <= r_cnt - 3'd1;
                        r_first <= 1'b1;
                    end
                end
                ST_TXWAIT: begin
                    r_first <= 1'b0;
                    if (w_idx_inc) begin
                        r_idx <= r_idx + 1'b1;
                    end
`ifdef COPRO_TX_HEADER_EN
                    if (w_next == ST_READ) begin
                        r_hdr_pending <= 1'b0;
                    end
`endif
                end
                default: ;
            endcase
        end
    end

endmodule
